prbs_generator: RTL and testbench

Byte-wide PRBS31 pattern source for the BER tester: drives 8 bits per enabled clock toward the DUT/serializer, bit-for-bit compatible with the team's PRBS31 byte checker. The block runs the x^31 + x^28 + 1 LFSR 8 steps per cycle. It supports synchronous reseeding, and can inject single-bit errors on demand or periodically to prove the receive-side error counting and lock logic end to end.

---
 rtl/prbs_generator.sv | 121 ++++++++++++
 tb/tb_prbs_generator.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/prbs_generator.sv
// Byte-wide PRBS31 (x^31 + x^28 + 1) source, 8 LFSR steps per enabled cycle.
// Define PRBS_GEN_ERR_INJ_EN to build the manual/periodic single-bit error injection and inj_cnt.
module prbs_generator #(
    parameter logic [30:0] SEED       = 31'h0000_0001,
    parameter int          ERR_PERIOD = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        reseed,
    input  logic        inj_req,
    input  logic [2:0]  inj_bit,
    output logic [7:0]  prbs,
    output logic        valid,
    output logic [15:0] inj_cnt
);

    logic [30:0] d_reg;
    logic [7:0]  prbs_reg;
    logic        valid_reg;
    logic [7:0]  nb;
    logic [7:0]  mask;
    logic        lockup;
    logic        advance;

    // nb[7] is the earliest serial bit: b[n] = b[n-31] ^ b[n-28]
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_next_byte
            assign nb[7-gi] = d_reg[30-gi] ^ d_reg[27-gi];
        end
    endgenerate

    assign lockup  = (d_reg == 31'd0);
    assign advance = en && !reseed && !lockup;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_reg     <= SEED;
            prbs_reg  <= 8'h00;
            valid_reg <= 1'b0;
        end else if (reseed) begin
            d_reg <= SEED;
        end else if (en) begin
            valid_reg <= 1'b1;
            if (lockup) begin
                d_reg    <= SEED;
                prbs_reg <= 8'h00;
            end else begin
                // The LFSR always shifts the clean byte; only the output sees the mask.
                d_reg    <= {d_reg[22:0], nb};
                prbs_reg <= nb ^ mask;
            end
        end else begin
            valid_reg <= 1'b0;
        end
    end

`ifdef PRBS_GEN_ERR_INJ_EN
    logic        pend_reg;
    logic [2:0]  pend_bit_reg;
    logic [31:0] per_cnt_reg;
    logic [2:0]  rot_reg;
    logic [15:0] inj_cnt_reg;
    logic        man_active;
    logic [2:0]  man_bit;
    logic        per_hit;
    logic [7:0]  man_mask;
    logic [7:0]  per_mask;

    assign man_active = pend_reg || inj_req;
    assign man_bit    = pend_reg ? pend_bit_reg : inj_bit;
    assign per_hit    = (ERR_PERIOD > 0) && (per_cnt_reg == 32'(ERR_PERIOD - 1));
    assign man_mask   = man_active ? (8'h01 << man_bit) : 8'h00;
    assign per_mask   = per_hit ? (8'h01 << rot_reg) : 8'h00;
    assign mask       = man_mask | per_mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_reg     <= 1'b0;
            pend_bit_reg <= 3'd0;
            per_cnt_reg  <= 32'd0;
            rot_reg      <= 3'd0;
            inj_cnt_reg  <= 16'h0000;
        end else begin
            if (reseed) begin
                per_cnt_reg <= 32'd0;
            end else if (advance) begin
                if (per_hit) begin
                    per_cnt_reg <= 32'd0;
                    rot_reg     <= rot_reg + 3'd1;
                end else if (ERR_PERIOD > 0) begin
                    per_cnt_reg <= per_cnt_reg + 32'd1;
                end
            end

            // First request wins until a byte consumes it.
            if (advance && man_active) begin
                pend_reg <= 1'b0;
            end else if (inj_req && !pend_reg) begin
                pend_reg     <= 1'b1;
                pend_bit_reg <= inj_bit;
            end

            if (advance && (mask != 8'h00) && (inj_cnt_reg != 16'hFFFF)) begin
                inj_cnt_reg <= inj_cnt_reg + 16'd1;
            end
        end
    end

    assign inj_cnt = inj_cnt_reg;
`else
    logic unused_inj;
    assign unused_inj = ^{inj_req, inj_bit, (ERR_PERIOD != 0)};
    assign mask       = 8'h00;
    assign inj_cnt    = 16'h0000;
`endif

    assign prbs  = prbs_reg;
    assign valid = valid_reg;

endmodule

// File: tb/tb_prbs_generator.sv
// Directed bench for prbs_generator: serial PRBS31 reference model plus hand-computed bytes.
module tb_prbs_generator;

`ifdef PRBS_GEN_ERR_INJ_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        reseed = 1'b0;
    logic        inj_req = 1'b0;
    logic [2:0]  inj_bit = 3'd0;
    logic        inj_off = 1'b0;
    logic [2:0]  inj_bit_off = 3'd0;

    logic [7:0]  prbs0, prbs1, prbs2;
    logic        valid0, valid1, valid2;
    logic [15:0] inj_cnt0, inj_cnt1, inj_cnt2;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [30:0] md;
    logic [7:0]  e;
    logic [7:0]  last_exp;
    logic [7:0]  hand [4];

    always #5 clk = ~clk;

    prbs_generator #(.SEED(31'h1), .ERR_PERIOD(0)) u0 (
        .clk(clk), .reset(reset), .en(en), .reseed(reseed),
        .inj_req(inj_req), .inj_bit(inj_bit),
        .prbs(prbs0), .valid(valid0), .inj_cnt(inj_cnt0));

    prbs_generator #(.SEED(31'h1), .ERR_PERIOD(4)) u1 (
        .clk(clk), .reset(reset), .en(en), .reseed(reseed),
        .inj_req(inj_off), .inj_bit(inj_bit_off),
        .prbs(prbs1), .valid(valid1), .inj_cnt(inj_cnt1));

    prbs_generator #(.SEED(31'h0), .ERR_PERIOD(0)) u2 (
        .clk(clk), .reset(reset), .en(en), .reseed(reseed),
        .inj_req(inj_off), .inj_bit(inj_bit_off),
        .prbs(prbs2), .valid(valid2), .inj_cnt(inj_cnt2));

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Bit-serial reference: one LFSR step per bit, earliest bit lands in bit 7.
    task automatic model_next(output logic [7:0] b);
        logic bit_n;
        b = 8'h00;
        if (md == 31'd0) begin
            md = 31'h1;
        end else begin
            for (int k = 0; k < 8; k++) begin
                bit_n = md[30] ^ md[27];
                md    = {md[29:0], bit_n};
                b     = {b[6:0], bit_n};
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic seed_start(input string tag);
        for (int i = 0; i < 4; i++) begin
            step();
            model_next(e);
            check({tag, "_hand"}, {8'h00, prbs0}, {8'h00, hand[i]});
            check({tag, "_model"}, {8'h00, prbs0}, {8'h00, e});
            last_exp = e;
        end
    endtask

    initial begin
        logic [7:0] pmask;
        hand[0] = 8'h00; hand[1] = 8'h00; hand[2] = 8'h00; hand[3] = 8'h12;
        md = 31'h1;

        // Reset state
        #12;
        check("rst_prbs", {8'h00, prbs0}, 16'h0000);
        check("rst_valid", {15'd0, valid0}, 16'h0000);
        check("rst_inj_cnt", inj_cnt0, 16'h0000);
        reset = 1'b1;

        // 32 bytes from reset: clean stream, periodic injection on u1, lock-up guard on u2
        en = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            step();
            model_next(e);
            last_exp = e;
            if (i <= 4) check("seed_hand", {8'h00, prbs0}, {8'h00, hand[i-1]});
            check("clean", {8'h00, prbs0}, {8'h00, e});
            check("valid", {15'd0, valid0}, 16'h0001);
            pmask = (INJ && (i % 4 == 0)) ? (8'h01 << ((i / 4) - 1)) : 8'h00;
            check("periodic", {8'h00, prbs1}, {8'h00, e ^ pmask});
            check("lockup", {7'd0, valid2, prbs2}, 16'h0100);
        end
        check("periodic_cnt", inj_cnt1, INJ ? 16'd8 : 16'd0);
        check("clean_cnt", inj_cnt0, 16'd0);

        for (int i = 0; i < 400; i++) begin
            step();
            model_next(e);
            last_exp = e;
            check("long", {8'h00, prbs0}, {8'h00, e});
        end

        // en low: hold byte, drop valid
        en = 1'b0;
        inj_req = 1'b1; inj_bit = 3'd3;
        step();
        check("hold_prbs", {8'h00, prbs0}, {8'h00, last_exp});
        check("hold_valid", {15'd0, valid0}, 16'h0000);
        inj_bit = 3'd5;
        step();
        inj_req = 1'b0;
        en = 1'b1;
        step();
        model_next(e);
        check("inj_bit3", {8'h00, prbs0}, {8'h00, e ^ (INJ ? 8'h08 : 8'h00)});
        step();
        model_next(e);
        check("after_inj", {8'h00, prbs0}, {8'h00, e});
        check("inj_cnt1", inj_cnt0, INJ ? 16'd1 : 16'd0);

        // Request coincident with en hits the same byte
        inj_req = 1'b1; inj_bit = 3'd0;
        step();
        inj_req = 1'b0;
        model_next(e);
        check("inj_same", {8'h00, prbs0}, {8'h00, e ^ (INJ ? 8'h01 : 8'h00)});
        step();
        model_next(e);
        last_exp = e;
        check("after_same", {8'h00, prbs0}, {8'h00, e});
        check("inj_cnt2", inj_cnt0, INJ ? 16'd2 : 16'd0);

        // Reseed wins over en; outputs hold for that cycle
        reseed = 1'b1;
        step();
        reseed = 1'b0;
        check("reseed_prbs", {8'h00, prbs0}, {8'h00, last_exp});
        check("reseed_valid", {15'd0, valid0}, 16'h0001);
        md = 31'h1;
        seed_start("reseed");

        // Asynchronous reset mid-burst
        step();
        model_next(e);
        check("pre_rst", {8'h00, prbs0}, {8'h00, e});
        #2 reset = 1'b0;
        #1;
        check("async_prbs", {8'h00, prbs0}, 16'h0000);
        check("async_valid", {15'd0, valid0}, 16'h0000);
        check("async_cnt", inj_cnt0, 16'h0000);
        step();
        reset = 1'b1;
        md = 31'h1;
        seed_start("restart");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
